// File: rtl/router_dest_sync.sv
// Destination latch, one-hot write steering and per-port read-timeout watchdog for the 1x3 router.
// Define ROUTER_TIMEOUT_EN to build the watchdog; otherwise soft_reset is tied low.
module router_dest_sync #(
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = 5
) (
  input  logic       clk1,
  input  logic       reset,
  input  logic       detect_add,
  input  logic [1:0] data_in_addr,
  input  logic       write_enb_reg,
  input  logic [2:0] read_enb,
  input  logic [2:0] empty,
  input  logic [2:0] full,
  output logic [2:0] write_enb,
  output logic       fifo_full,
  output logic [2:0] vld_out,
  output logic [2:0] soft_reset,
  output logic       addr_err
);

  logic [1:0] r_dest;
  logic       r_dest_valid;
  logic       r_addr_err;
  logic [2:0] w_write_enb;
  logic       w_fifo_full;

  // The address only changes on detect_add, so a same-cycle write still uses the old dest.
  always_ff @(posedge clk1 or negedge reset) begin
    if (!reset) begin
      r_dest       <= 2'b00;
      r_dest_valid <= 1'b0;
      r_addr_err   <= 1'b0;
    end else if (detect_add) begin
      r_dest       <= data_in_addr;
      r_dest_valid <= (data_in_addr != 2'b11);
      r_addr_err   <= (data_in_addr == 2'b11);
    end else begin
      r_dest       <= r_dest;
      r_dest_valid <= r_dest_valid;
      r_addr_err   <= r_addr_err;
    end
  end

  always_comb begin
    w_write_enb = 3'b000;
    w_fifo_full = 1'b0;
    if (r_dest_valid) begin
      case (r_dest)
        2'b00: begin
          w_write_enb = {2'b00, write_enb_reg};
          w_fifo_full = full[0];
        end
        2'b01: begin
          w_write_enb = {1'b0, write_enb_reg, 1'b0};
          w_fifo_full = full[1];
        end
        2'b10: begin
          w_write_enb = {write_enb_reg, 2'b00};
          w_fifo_full = full[2];
        end
        default: begin
          w_write_enb = 3'b000;
          w_fifo_full = 1'b0;
        end
      endcase
    end else begin
      w_write_enb = 3'b000;
      w_fifo_full = 1'b0;
    end
  end

  assign write_enb = w_write_enb;
  assign fifo_full = w_fifo_full;
  assign vld_out   = ~empty;
  assign addr_err  = r_addr_err;

`ifdef ROUTER_TIMEOUT_EN
  localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LP_CNT_ONE = CNT_W'(1);

  logic [2:0] r_soft_reset;

  for (genvar g = 0; g < 3; g++) begin : g_wdog
    logic [CNT_W-1:0] r_cnt;

    // Clearing at TIMEOUT-1 both fires the pulse and keeps the counter from wrapping.
    always_ff @(posedge clk1 or negedge reset) begin
      if (!reset) begin
        r_cnt           <= '0;
        r_soft_reset[g] <= 1'b0;
      end else if (!vld_out[g] || read_enb[g]) begin
        r_cnt           <= '0;
        r_soft_reset[g] <= 1'b0;
      end else if (r_cnt == LP_CNT_MAX) begin
        r_cnt           <= '0;
        r_soft_reset[g] <= 1'b1;
      end else begin
        r_cnt           <= r_cnt + LP_CNT_ONE;
        r_soft_reset[g] <= 1'b0;
      end
    end
  end

  assign soft_reset = r_soft_reset;
`else
  logic [2:0] w_unused_cfg;
  assign w_unused_cfg = read_enb ^ 3'(TIMEOUT) ^ 3'(CNT_W);
  assign soft_reset   = 3'b000;
`endif

endmodule

// File: tb/tb_router_dest_sync.sv
// Directed self-checking bench for router_dest_sync; watchdog checks follow ROUTER_TIMEOUT_EN.
module tb_router_dest_sync;

`ifdef ROUTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk1 = 1'b0;
  logic       reset;
  logic       detect_add;
  logic [1:0] data_in_addr;
  logic       write_enb_reg;
  logic [2:0] read_enb;
  logic [2:0] empty;
  logic [2:0] full;
  logic [2:0] write_enb;
  logic       fifo_full;
  logic [2:0] vld_out;
  logic [2:0] soft_reset;
  logic       addr_err;

  int checks   = 0;
  int failures = 0;

  router_dest_sync #(.TIMEOUT(30), .CNT_W(5)) dut (
    .clk1         (clk1),
    .reset        (reset),
    .detect_add   (detect_add),
    .data_in_addr (data_in_addr),
    .write_enb_reg(write_enb_reg),
    .read_enb     (read_enb),
    .empty        (empty),
    .full         (full),
    .write_enb    (write_enb),
    .fifo_full    (fifo_full),
    .vld_out      (vld_out),
    .soft_reset   (soft_reset),
    .addr_err     (addr_err)
  );

  always #5 clk1 = ~clk1;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  initial begin
    reset = 1'b0; detect_add = 1'b0; data_in_addr = 2'b00; write_enb_reg = 1'b0;
    read_enb = 3'b000; empty = 3'b111; full = 3'b000;
    tick(); tick();
    chk("rst_write_enb", {5'd0, write_enb}, 8'h00);
    chk("rst_fifo_full", {7'd0, fifo_full}, 8'h00);
    chk("rst_vld_out", {5'd0, vld_out}, 8'h00);
    chk("rst_soft_reset", {5'd0, soft_reset}, 8'h00);
    chk("rst_addr_err", {7'd0, addr_err}, 8'h00);
    reset = 1'b1;
    tick();

    // Port 1 packet
    detect_add = 1'b1; data_in_addr = 2'b01;
    tick();
    detect_add = 1'b0; write_enb_reg = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("p1_write_enb", {5'd0, write_enb}, 8'h02);
      chk("p1_fifo_full", {7'd0, fifo_full}, 8'h00);
      tick();
    end
    full = 3'b010; #1;
    chk("p1_full_return", {7'd0, fifo_full}, 8'h01);
    full = 3'b101; #1;
    chk("p1_other_full", {7'd0, fifo_full}, 8'h00);
    full = 3'b000; write_enb_reg = 1'b0;

    // Invalid address blocks writes and sets the sticky error
    detect_add = 1'b1; data_in_addr = 2'b11;
    tick();
    detect_add = 1'b0; write_enb_reg = 1'b1; full = 3'b111; #1;
    chk("bad_write_enb", {5'd0, write_enb}, 8'h00);
    chk("bad_addr_err", {7'd0, addr_err}, 8'h01);
    chk("bad_fifo_full", {7'd0, fifo_full}, 8'h00);
    full = 3'b000;
    tick();
    chk("bad_err_sticky", {7'd0, addr_err}, 8'h01);
    write_enb_reg = 1'b0; detect_add = 1'b1; data_in_addr = 2'b10;
    tick();
    detect_add = 1'b0;
    chk("p2_addr_err_clr", {7'd0, addr_err}, 8'h00);
    write_enb_reg = 1'b1; #1;
    chk("p2_write_enb", {5'd0, write_enb}, 8'h04);

    // Same-cycle detect_add uses the previous dest
    detect_add = 1'b1; data_in_addr = 2'b00; #1;
    chk("same_cyc_old_dest", {5'd0, write_enb}, 8'h04);
    tick();
    detect_add = 1'b0; #1;
    chk("same_cyc_new_dest", {5'd0, write_enb}, 8'h01);
    write_enb_reg = 1'b0;

    // vld_out follows ~empty with no clock edge in between
    empty = 3'b010; #1;
    chk("vld_out_101", {5'd0, vld_out}, 8'h05);
    empty = 3'b111; #1;

    // Watchdog: port 0 pending, never read
    tick();
    empty = 3'b110;
    for (int k = 1; k <= 31; k++) begin
      tick();
      chk($sformatf("to_k%0d", k), {5'd0, soft_reset}, (TO_EN && k == 30) ? 8'h01 : 8'h00);
    end
    empty = 3'b111;
    tick();

    // Watchdog: read at cycle 20 restarts the count
    empty = 3'b110;
    for (int k = 1; k <= 50; k++) begin
      read_enb = (k == 20) ? 3'b001 : 3'b000;
      tick();
      chk($sformatf("to_rd_k%0d", k), {5'd0, soft_reset}, (TO_EN && k == 50) ? 8'h01 : 8'h00);
    end
    read_enb = 3'b000; empty = 3'b111;
    tick();

    // Reset mid-packet with port 2 counter at 15
    detect_add = 1'b1; data_in_addr = 2'b01;
    tick();
    detect_add = 1'b0; write_enb_reg = 1'b1; empty = 3'b011;
    for (int k = 0; k < 15; k++) tick();
    chk("mid_write_enb", {5'd0, write_enb}, 8'h02);
    reset = 1'b0; #1;
    chk("mid_rst_write_enb", {5'd0, write_enb}, 8'h00);
    chk("mid_rst_soft_reset", {5'd0, soft_reset}, 8'h00);
    #1 reset = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      chk($sformatf("post_rst_we_k%0d", k), {5'd0, write_enb}, 8'h00);
      chk($sformatf("post_rst_sr_k%0d", k), {5'd0, soft_reset}, (TO_EN && k == 30) ? 8'h04 : 8'h00);
    end
    detect_add = 1'b1; data_in_addr = 2'b00; #1;
    chk("redetect_same_cyc", {5'd0, write_enb}, 8'h00);
    tick();
    detect_add = 1'b0; #1;
    chk("redetect_write_enb", {5'd0, write_enb}, 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
